sparse_coo_spmm_seq: RTL and testbench
======================================

// Module: sparse_coo_spmm_seq
// PURPOSE
//  Sequential, parametrised sparse x sparse matrix multiply, C = A*B, with A and B given in COO form.
//  Loads nonzeros of A and B over one valid/ready stream into on-chip entry buffers.
//  Accumulates matched products (A.col==B.row) into an NxN accumulator array, one pair per cycle.
//  Drains dense C in row-major order over a valid/ready output stream.
//  Generalises the fixed 4x4 / 4-nonzero combinational COO multiplier to any N, nonzero depth and width.
// PARAMETERS
//  N        4   matrix dimension (NxN); >=2
//  NNZ_MAX  8   max stored nonzeros per operand (A and B each)
//  DW       32  operand data width, unsigned
//  AW       32  accumulator/output width, unsigned; AW<=2*DW
// PORTS
//  clk        in   1              clock, rising edge
//  rst        in   1              synchronous reset, active-high
//  start      in   1              begin a job; honoured only in IDLE
//  in_valid   in   1              input entry valid
//  in_ready   out  1              input entry accepted when in_valid&in_ready
//  in_sel     in   1              0 = entry of A, 1 = entry of B
//  in_row     in   $clog2(N)      entry row index
//  in_col     in   $clog2(N)      entry column index
//  in_data    in   DW             entry value
//  in_last    in   1              final entry of the load phase
//  out_valid  out  1              C element valid
//  out_ready  in   1              C element consumed when out_valid&out_ready
//  out_row    out  $clog2(N)      C row index
//  out_col    out  $clog2(N)      C column index
//  out_data   out  AW             C[out_row][out_col]
//  out_last   out  1              high with element (N-1,N-1)
//  busy       out  1              high in any state other than IDLE
//  done       out  1              one-cycle pulse on DRAIN->IDLE
//  err_full   out  1              sticky: entry dropped on full buffer; cleared on start
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; buffer counts 0; accumulators 0; err_full 0.
//  FSM IDLE -> LOAD (start) -> COMPUTE (accepted in_last) -> DRAIN (all pairs done) -> IDLE (out_last taken).
//  IDLE->LOAD on start: clear all N*N accumulators, both counts, err_full; start ignored when busy.
//  LOAD: in_ready=1; accepted entry written to the buffer selected by in_sel at its count, count++.
//   A write to a full buffer (count==NNZ_MAX) is dropped, sets err_full, in_last still honoured.
//  COMPUTE: in_ready=0; visit pairs (i,j), i<nA outer, j<nB inner, one per cycle.
//   If A[i].col==B[j].row: acc[A[i].row][B[j].col] += A[i].data*B[j].data.
//   Product is 2*DW bits, truncated to its low AW bits before the add.
//   Duplicate coordinates sum naturally. Takes max(nA*nB,1) cycles (nA==0 or nB==0 -> 1 cycle, no updates).
//  DRAIN: elements (r,c) in row-major order; out_* held stable while out_valid&!out_ready.
//   Advance only on the handshake. N*N beats minimum latency, no bubbles when out_ready=1.
//   done pulses the cycle after the out_last handshake; state is IDLE that cycle.
//  Arithmetic: unsigned; the default accumulate wraps modulo 2^AW.
//  rst mid-job: returns to the reset state next edge; partial results discarded.
//  in_valid outside LOAD: ignored (in_ready=0). out_ready outside DRAIN: ignored.
// CONFIGURATION
//  SPMM_SAT_EN defined: accumulate saturates at 2^AW-1; truncated product saturates likewise if the high bits are nonzero.
//  SPMM_SAT_EN undefined: truncate/wrap as above.
// STRUCTURE
//  sparse_coo_pkg: state enum (IDLE/LOAD/COMPUTE/DRAIN); idx/count width helpers; coo_entry_t {row,col,data}.
//  Sub-module coo_entry_buf (NNZ_MAX-deep coo_entry_t store + count + full), instantiated for A and B.
//  Top owns the FSM, pair counters, multiplier, accumulator array and drain counter.
// TESTING
//  1 Identity: A=I (4 entries, 1), B dense 1..16 -> C equals B, out_last on 16th beat, done one cycle later.
//  2 Reference case: A{(0,1)=3,(2,0)=5}, B{(1,3)=7,(0,0)=2} -> C03=21, C20=10, all others 0.
//  3 Duplicates: A{(1,1)=2,(1,1)=3}, B{(1,2)=4} -> C12=20.
//  4 Overflow: NNZ_MAX+1 A entries -> err_full=1, last entry dropped; next start clears err_full.
//  5 Backpressure: out_ready toggled 1/0 each cycle -> every beat held stable, order and values intact.
//  6 Wrap/sat: AW=DW=8, A(0,0)=200, B(0,0)=2 -> C00=144 (wrap) / 255 (SPMM_SAT_EN); also check rst mid-COMPUTE -> IDLE, outputs 0.

Source files
------------

// File: rtl/sparse_coo_pkg.sv
// sparse_coo_pkg: shared FSM states, width helpers and the default COO entry type.
//   No ports. Imported by coo_entry_buf and sparse_coo_spmm_seq.
package sparse_coo_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction
    localparam int COO_N  = 4;
    localparam int COO_DW = 32;
    typedef struct packed {
        logic [$clog2(COO_N)-1:0] row;
        logic [$clog2(COO_N)-1:0] col;
        logic [COO_DW-1:0]        data;
    } coo_entry_t;
endpackage

// File: rtl/coo_entry_buf.sv
// coo_entry_buf: DEPTH-deep COO entry store with fill count; writes to a full store are dropped.
//   clk, rst   clock, synchronous active-high reset (count only)
//   clr        empty the store (start of a job)
//   wr, wdata  append one entry at position count
//   raddr      combinational read address -> rdata
//   count      number of stored entries; full when count == DEPTH
module coo_entry_buf
    import sparse_coo_pkg::*;
#(
    parameter int  DEPTH   = 8,
    parameter type entry_t = coo_entry_t
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    wr,
    input  entry_t                  wdata,
    input  logic [idx_w(DEPTH)-1:0] raddr,
    output entry_t                  rdata,
    output logic [cnt_w(DEPTH)-1:0] count,
    output logic                    full
);
    localparam int IW = idx_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    entry_t mem [DEPTH];
    assign full  = count == CW'(DEPTH);
    assign rdata = mem[raddr];
    always_ff @(posedge clk) begin
        if (rst || clr) count <= '0;
        else if (wr && !full) count <= count + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (wr && !full) mem[count[IW-1:0]] <= wdata;
    end
endmodule

// File: rtl/sparse_coo_spmm_seq.sv
// sparse_coo_spmm_seq: sequential COO sparse x sparse multiply C = A*B, drained densely in row-major order.
//   Ports: clk, rst (sync, active-high); start; load stream in_valid/in_ready/in_sel/in_row/in_col/in_data/in_last;
//   drain stream out_valid/out_ready/out_row/out_col/out_data/out_last; status busy, done, err_full.
//   Build option SPMM_SAT_EN: saturating product truncation and accumulate instead of wrap.
module sparse_coo_spmm_seq
    import sparse_coo_pkg::*;
#(
    parameter int N       = 4,
    parameter int NNZ_MAX = 8,
    parameter int DW      = 32,
    parameter int AW      = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sel,
    input  logic [idx_w(N)-1:0] in_row,
    input  logic [idx_w(N)-1:0] in_col,
    input  logic [DW-1:0]       in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [idx_w(N)-1:0] out_row,
    output logic [idx_w(N)-1:0] out_col,
    output logic [AW-1:0]       out_data,
    output logic                out_last,
    output logic                busy,
    output logic                done,
    output logic                err_full
);
    localparam int IW = idx_w(N);
    localparam int EW = idx_w(NNZ_MAX);
    localparam int CW = cnt_w(NNZ_MAX);
    typedef struct packed {
        logic [IW-1:0] row;
        logic [IW-1:0] col;
        logic [DW-1:0] data;
    } entry_t;
    state_t        state, state_n;
    entry_t        a, b, wentry;
    logic [CW-1:0] i, j, na, nb;
    logic [IW-1:0] r, c;
    logic [AW-1:0] acc [N][N];
    logic [AW-1:0] ptr, acc_new;
    logic          a_full, b_full, start_job, accept, take, empty, last_pair, hit;
    assign start_job = state == IDLE && start;
    assign accept    = state == LOAD && in_valid;
    assign take      = out_valid && out_ready;
    assign empty     = na == '0 || nb == '0;
    assign last_pair = empty || (i == na - 1'b1 && j == nb - 1'b1);
    assign hit       = state == COMPUTE && !empty && a.col == b.row;
    assign wentry    = {in_row, in_col, in_data};
    coo_entry_buf #(.DEPTH(NNZ_MAX), .entry_t(entry_t)) u_buf_a (
        .clk(clk), .rst(rst), .clr(start_job), .wr(accept && !in_sel), .wdata(wentry),
        .raddr(i[EW-1:0]), .rdata(a), .count(na), .full(a_full)
    );
    coo_entry_buf #(.DEPTH(NNZ_MAX), .entry_t(entry_t)) u_buf_b (
        .clk(clk), .rst(rst), .clr(start_job), .wr(accept && in_sel), .wdata(wentry),
        .raddr(j[EW-1:0]), .rdata(b), .count(nb), .full(b_full)
    );
`ifdef SPMM_SAT_EN
    logic [2*DW-1:0] prod;
    logic [AW:0]     sum;
    assign prod    = (2*DW)'(a.data) * (2*DW)'(b.data);
    assign ptr     = (prod >> AW) != '0 ? '1 : prod[AW-1:0];
    assign sum     = {1'b0, acc[a.row][b.col]} + {1'b0, ptr};
    assign acc_new = sum[AW] ? '1 : sum[AW-1:0];
`else
    // Low AW bits of the product depend only on the low AW bits of each operand.
    assign ptr     = AW'(a.data) * AW'(b.data);
    assign acc_new = acc[a.row][b.col] + ptr;
`endif
    assign busy      = state != IDLE;
    assign in_ready  = state == LOAD;
    assign out_valid = state == DRAIN;
    assign out_row   = out_valid ? r : '0;
    assign out_col   = out_valid ? c : '0;
    assign out_data  = out_valid ? acc[r][c] : '0;
    assign out_last  = out_valid && r == IW'(N - 1) && c == IW'(N - 1);
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = LOAD;
            LOAD:    if (in_valid && in_last) state_n = COMPUTE;
            COMPUTE: if (last_pair) state_n = DRAIN;
            DRAIN:   if (take && out_last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        done <= !rst && state == DRAIN && take && out_last;
        if (rst || start_job) begin
            err_full <= 1'b0;
            i <= '0;
            j <= '0;
            r <= '0;
            c <= '0;
            for (int y = 0; y < N; y++)
                for (int x = 0; x < N; x++)
                    acc[y][x] <= '0;
        end else begin
            if (accept && (in_sel ? b_full : a_full)) err_full <= 1'b1;
            if (state == COMPUTE) begin
                if (hit) acc[a.row][b.col] <= acc_new;
                if (j == nb - 1'b1) begin
                    j <= '0;
                    i <= i + 1'b1;
                end else begin
                    j <= j + 1'b1;
                end
            end
            if (take) begin
                c <= c == IW'(N - 1) ? '0 : c + 1'b1;
                if (c == IW'(N - 1)) r <= r == IW'(N - 1) ? '0 : r + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sparse_coo_spmm_seq.sv
// tb_sparse_coo_spmm_seq: directed bench for a 32-bit and an 8-bit instance driven in lockstep.
module tb_sparse_coo_spmm_seq;
    localparam int NZ = 16;
    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_sel, in_last, out_ready;
    logic [1:0]  in_row, in_col;
    logic [31:0] in_data;
    logic        in_ready, out_valid, out_last, busy, done, err_full;
    logic [1:0]  out_row, out_col;
    logic [31:0] out_data;
    logic        s_in_ready, s_out_valid, s_out_last, s_busy, s_done, s_err_full;
    logic [1:0]  s_out_row, s_out_col;
    logic [7:0]  s_out_data;
    logic [31:0] got [16];
    logic [7:0]  s_got [16];
    int tests = 0;
    int fails = 0;
    always #5 clk = ~clk;
    sparse_coo_spmm_seq #(.N(4), .NNZ_MAX(NZ), .DW(32), .AW(32)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_row(in_row), .in_col(in_col), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_col(out_col),
        .out_data(out_data), .out_last(out_last), .busy(busy), .done(done), .err_full(err_full)
    );
    sparse_coo_spmm_seq #(.N(4), .NNZ_MAX(NZ), .DW(8), .AW(8)) dut_s (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_sel(in_sel), .in_row(in_row), .in_col(in_col), .in_data(in_data[7:0]), .in_last(in_last),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_row(s_out_row), .out_col(s_out_col),
        .out_data(s_out_data), .out_last(s_out_last), .busy(s_busy), .done(s_done), .err_full(s_err_full)
    );
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask
    task automatic send(input logic sel, input int r, input int c, input int d, input logic last);
        in_valid = 1'b1;
        in_sel   = sel;
        in_row   = 2'(r);
        in_col   = 2'(c);
        in_data  = 32'(d);
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask
    task automatic load_identity();
        do_start();
        for (int k = 0; k < 4; k++) send(1'b0, k, k, 1, 1'b0);
        for (int k = 0; k < 16; k++) send(1'b1, k / 4, k % 4, k + 1, k == 15);
    endtask
    task automatic drain(input bit toggle);
        int k = 0;
        bit fin = 0;
        bit held = 0;
        logic [35:0] hv = '0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            out_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            #1;
            if (held) begin
                tests++;
                if ({out_row, out_col, out_data} !== hv) begin
                    fails++;
                    $display("FAIL hold beat %0d: got %h expected %h", k, {out_row, out_col, out_data}, hv);
                end
            end
            held = 0;
            if (out_valid && out_ready) begin
                tests++;
                if (out_row !== 2'(k / 4) || out_col !== 2'(k % 4)) begin
                    fails++;
                    $display("FAIL order beat %0d: got (%0d,%0d) expected (%0d,%0d)", k, out_row, out_col, k / 4, k % 4);
                end
                tests++;
                if (out_last !== (k == 15)) begin
                    fails++;
                    $display("FAIL out_last beat %0d: got %b expected %b", k, out_last, k == 15);
                end
                got[k]   = out_data;
                s_got[k] = s_out_data;
                fin = out_last;
                k++;
            end else if (out_valid) begin
                held = 1;
                hv = {out_row, out_col, out_data};
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        tests++;
        if (!fin) begin
            fails++;
            $display("FAIL drain timeout: got %0d beats expected 16", k);
        end
        tests++;
        if ({done, busy} !== 2'b10) begin
            fails++;
            $display("FAIL done/busy after last: got %b expected 10", {done, busy});
        end
    endtask
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_last = 1'b0;
        in_row = '0; in_col = '0; in_data = '0; out_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        tests++;
        if ({busy, in_ready, out_valid, out_last, done, err_full, out_row, out_col, out_data} !== '0) begin
            fails++;
            $display("FAIL reset outputs: got %h expected 0", {busy, in_ready, out_valid, out_last, done, err_full, out_row, out_col, out_data});
        end
        tests++;
        if ({s_busy, s_in_ready, s_out_valid, s_out_last, s_done, s_err_full, s_out_row, s_out_col, s_out_data} !== '0) begin
            fails++;
            $display("FAIL reset outputs 8b: got %h expected 0", {s_busy, s_in_ready, s_out_valid, s_out_last, s_done, s_err_full, s_out_row, s_out_col, s_out_data});
        end
    endtask
    task automatic test_identity();
        load_identity();
        drain(1'b0);
        for (int k = 0; k < 16; k++) begin
            tests++;
            if (got[k] !== 32'(k + 1)) begin
                fails++;
                $display("FAIL identity C[%0d]: got %0d expected %0d", k, got[k], k + 1);
            end
        end
    endtask
    task automatic test_reference();
        do_start();
        send(1'b0, 0, 1, 3, 1'b0);
        send(1'b0, 2, 0, 5, 1'b0);
        send(1'b1, 1, 3, 7, 1'b0);
        send(1'b1, 0, 0, 2, 1'b1);
        drain(1'b0);
        for (int k = 0; k < 16; k++) begin
            tests++;
            if (got[k] !== (k == 3 ? 32'd21 : k == 8 ? 32'd10 : 32'd0)) begin
                fails++;
                $display("FAIL reference C[%0d]: got %0d", k, got[k]);
            end
        end
    endtask
    task automatic test_duplicates();
        do_start();
        send(1'b0, 1, 1, 2, 1'b0);
        send(1'b0, 1, 1, 3, 1'b0);
        send(1'b1, 1, 2, 4, 1'b1);
        drain(1'b0);
        for (int k = 0; k < 16; k++) begin
            tests++;
            if (got[k] !== (k == 6 ? 32'd20 : 32'd0)) begin
                fails++;
                $display("FAIL duplicates C[%0d]: got %0d", k, got[k]);
            end
        end
    endtask
    task automatic test_overflow();
        do_start();
        send(1'b1, 0, 0, 1, 1'b0);
        for (int k = 0; k < NZ; k++) send(1'b0, 0, 0, 1, 1'b0);
        send(1'b0, 0, 0, 100, 1'b1);
        tests++;
        if ({err_full, busy, in_ready} !== 3'b110) begin
            fails++;
            $display("FAIL overflow flag: got %b expected 110", {err_full, busy, in_ready});
        end
        drain(1'b0);
        tests++;
        if (got[0] !== 32'd16) begin
            fails++;
            $display("FAIL overflow C00: got %0d expected 16", got[0]);
        end
        tests++;
        if (err_full !== 1'b1) begin
            fails++;
            $display("FAIL err_full sticky: got %b expected 1", err_full);
        end
        do_start();
        tests++;
        if (err_full !== 1'b0) begin
            fails++;
            $display("FAIL err_full clear on start: got %b expected 0", err_full);
        end
        send(1'b0, 1, 1, 9, 1'b1);
        drain(1'b0);
        for (int k = 0; k < 16; k++) begin
            tests++;
            if (got[k] !== 32'd0) begin
                fails++;
                $display("FAIL empty-B C[%0d]: got %0d expected 0", k, got[k]);
            end
        end
    endtask
    task automatic test_back_to_back();
        load_identity();
        drain(1'b1);
        for (int k = 0; k < 16; k++) begin
            tests++;
            if (got[k] !== 32'(k + 1)) begin
                fails++;
                $display("FAIL backpressure C[%0d]: got %0d expected %0d", k, got[k], k + 1);
            end
        end
    endtask
    task automatic test_wrap();
        logic [7:0] s_exp;
`ifdef SPMM_SAT_EN
        s_exp = 8'd255;
`else
        s_exp = 8'd144;
`endif
        do_start();
        send(1'b0, 0, 0, 200, 1'b0);
        send(1'b1, 0, 0, 2, 1'b1);
        drain(1'b0);
        tests++;
        if (got[0] !== 32'd400) begin
            fails++;
            $display("FAIL wide C00: got %0d expected 400", got[0]);
        end
        for (int k = 0; k < 16; k++) begin
            tests++;
            if (s_got[k] !== (k == 0 ? s_exp : 8'd0)) begin
                fails++;
                $display("FAIL narrow C[%0d]: got %0d expected %0d", k, s_got[k], k == 0 ? s_exp : 8'd0);
            end
        end
    endtask
    task automatic test_reset_mid();
        load_identity();
        repeat (5) step();
        tests++;
        if ({busy, in_ready, out_valid} !== 3'b100) begin
            fails++;
            $display("FAIL mid-compute state: got %b expected 100", {busy, in_ready, out_valid});
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++;
        if ({busy, in_ready, out_valid, out_last, done, err_full, out_row, out_col, out_data} !== '0) begin
            fails++;
            $display("FAIL mid-compute reset: got %h expected 0", {busy, in_ready, out_valid, out_last, done, err_full, out_row, out_col, out_data});
        end
        tests++;
        if ({s_busy, s_in_ready, s_out_valid, s_out_data} !== '0) begin
            fails++;
            $display("FAIL mid-compute reset 8b: got %h expected 0", {s_busy, s_in_ready, s_out_valid, s_out_data});
        end
    endtask
    initial begin
        test_reset();
        test_identity();
        test_reference();
        test_duplicates();
        test_overflow();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
